// File: rtl/gpu_compute_pkg.sv
// -----------------------------------------------------------------------------
// gpu_compute_pkg
// Shared definitions for the compute datapath blocks.
//   dpe_state_t        : dot-product engine control states
//   sat_umax/smax/smin : saturation limits for a w-bit accumulator, returned
//                        in a 64-bit container; callers keep the low w bits.
// -----------------------------------------------------------------------------
package gpu_compute_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dpe_state_t;

    localparam int SAT_LIMIT_BITS = 64;

    // Unsigned limit: w ones.
    function automatic logic [SAT_LIMIT_BITS-1:0] sat_umax(input int w);
        logic [SAT_LIMIT_BITS-1:0] r;
        if (w >= SAT_LIMIT_BITS) r = '1;
        else                     r = (64'd1 << w) - 64'd1;
        return r;
    endfunction

    // Signed max: 0111...1 in w bits.
    function automatic logic [SAT_LIMIT_BITS-1:0] sat_smax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Signed min: 1000...0 in w bits (upper container bits are zero).
    function automatic logic [SAT_LIMIT_BITS-1:0] sat_smin(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/lane_mult.sv
// -----------------------------------------------------------------------------
// lane_mult
// One multiplier lane with zero-operand skipping and a registered product.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : operand beat accepted this cycle
//   signed_mode : 1 = two's complement operands
//   a, b        : operands
//   prod        : registered product (0 for a skipped lane)
//   skip        : combinational flag, a or b is zero for the current beat
// When a lane is skipped the multiplier sees its previous operands, so the
// array does not toggle for a product that is known to be zero.
// -----------------------------------------------------------------------------
module lane_mult
    import gpu_compute_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      signed_mode,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic [2*DATA_WIDTH-1:0]   prod,
    output logic                      skip
);

    localparam int PROD_W = 2 * DATA_WIDTH;

    logic                  zero_op;
    logic [DATA_WIDTH-1:0] a_hold_reg, b_hold_reg;
    logic [DATA_WIDTH-1:0] mult_a, mult_b;
    logic [PROD_W-1:0]     uprod, sprod, prod_reg;

    assign zero_op = (a == '0) || (b == '0);
    assign skip    = zero_op;

    // Operand isolation: a skipped lane keeps feeding the held operands.
    assign mult_a = zero_op ? a_hold_reg : a;
    assign mult_b = zero_op ? b_hold_reg : b;

    assign uprod = {{DATA_WIDTH{1'b0}}, mult_a} * {{DATA_WIDTH{1'b0}}, mult_b};
    assign sprod = $signed({{DATA_WIDTH{mult_a[DATA_WIDTH-1]}}, mult_a}) *
                   $signed({{DATA_WIDTH{mult_b[DATA_WIDTH-1]}}, mult_b});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_hold_reg <= '0;
            b_hold_reg <= '0;
            prod_reg   <= '0;
        end else if (en) begin
            if (zero_op) begin
                prod_reg <= '0;
            end else begin
                a_hold_reg <= a;
                b_hold_reg <= b;
                prod_reg   <= signed_mode ? sprod : uprod;
            end
        end
    end

    assign prod = prod_reg;

endmodule

// File: rtl/dot_product_engine.sv
// -----------------------------------------------------------------------------
// dot_product_engine
// Streams vec_len beats of LANES operand pairs and accumulates their dot
// product with optional saturation.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, vec_len        : launch a run of vec_len beats (IDLE only)
//   signed_mode, sat_en   : arithmetic mode, latched on start
//   valid_in, ready_in    : beat handshake (ready only in ACCUM)
//   a_vec, b_vec          : packed lane operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   result, result_valid  : final sum, held until result_ready
//   result_ready          : consumer handshake, returns engine to IDLE
//   busy                  : engine not idle
//   overflow              : sticky accumulator overflow for this run
//   skip_count            : lane products skipped for a zero operand
// Pipeline: stage 1 = lane products (lane_mult), stage 2 = adder tree +
// accumulate. The result register loads one cycle after DONE is entered,
// so result_valid rises three edges after the last accepted beat.
// -----------------------------------------------------------------------------
module dot_product_engine
    import gpu_compute_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int LANES      = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [LEN_WIDTH-1:0]              vec_len,
    input  logic                              signed_mode,
    input  logic                              sat_en,
    input  logic                              valid_in,
    output logic                              ready_in,
    input  logic [LANES*DATA_WIDTH-1:0]       a_vec,
    input  logic [LANES*DATA_WIDTH-1:0]       b_vec,
    output logic [ACC_WIDTH-1:0]              result,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic                              busy,
    output logic                              overflow,
    output logic [LEN_WIDTH+$clog2(LANES):0]  skip_count
);

    localparam int PROD_W      = 2 * DATA_WIDTH;
    localparam int EXT_W       = ACC_WIDTH - PROD_W;
    localparam int SKIP_W      = LEN_WIDTH + $clog2(LANES) + 1;
    localparam int TREE_LEVELS = $clog2(LANES);
    localparam int TREE_LEAVES = 1 << TREE_LEVELS;

    localparam logic [SAT_LIMIT_BITS-1:0] UMAX_64 = sat_umax(ACC_WIDTH);
    localparam logic [SAT_LIMIT_BITS-1:0] SMAX_64 = sat_smax(ACC_WIDTH);
    localparam logic [SAT_LIMIT_BITS-1:0] SMIN_64 = sat_smin(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0]      SAT_UMAX = UMAX_64[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0]      SAT_SMAX = SMAX_64[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0]      SAT_SMIN = SMIN_64[ACC_WIDTH-1:0];

    dpe_state_t            state_reg, state_next;
    logic [LEN_WIDTH-1:0]  len_reg, beat_cnt_reg, beat_cnt_next;
    logic                  signed_reg, sat_reg;
    logic                  drain_cnt_reg;
    logic                  s1_valid_reg;
    logic [ACC_WIDTH-1:0]  acc_reg, result_reg;
    logic                  clamped_reg, overflow_reg, result_valid_reg;
    logic [SKIP_W-1:0]     skip_reg, skip_beat;

    logic                  accept, start_ok;
    logic [LANES-1:0]      lane_skip;
    logic [PROD_W-1:0]     lane_prod [LANES];
    logic [ACC_WIDTH-1:0]  lane_ext  [LANES];
    logic [ACC_WIDTH-1:0]  tree_sum;
    logic [ACC_WIDTH:0]    acc_wide;
    logic                  acc_ovf;
    logic [ACC_WIDTH-1:0]  sat_val, acc_next;

    assign accept        = valid_in && (state_reg == ST_ACCUM);
    assign start_ok      = start && (state_reg == ST_IDLE);
    assign beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);

    // ---------------- stage 1: lane multipliers ----------------
    genvar gi, gl;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            lane_mult #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .clk         (clk),
                .rst_n       (rst_n),
                .en          (accept),
                .signed_mode (signed_reg),
                .a           (a_vec[gi*DATA_WIDTH +: DATA_WIDTH]),
                .b           (b_vec[gi*DATA_WIDTH +: DATA_WIDTH]),
                .prod        (lane_prod[gi]),
                .skip        (lane_skip[gi])
            );
            assign lane_ext[gi] = {{EXT_W{signed_reg & lane_prod[gi][PROD_W-1]}}, lane_prod[gi]};
        end

        // ---------------- stage 2: adder tree ----------------
        // One array per level keeps every node a distinct variable.
        // ACC_WIDTH leaves room for the full tree, so the tree never overflows.
        for (gl = 0; gl <= TREE_LEVELS; gl++) begin : g_lvl
            localparam int N = TREE_LEAVES >> gl;
            logic [ACC_WIDTH-1:0] node [N];
            for (gi = 0; gi < N; gi++) begin : g_node
                if (gl == 0) begin : g_leaf
                    if (gi < LANES) begin : g_used
                        assign node[gi] = lane_ext[gi];
                    end else begin : g_pad
                        assign node[gi] = '0;
                    end
                end else begin : g_add
                    assign node[gi] = g_lvl[gl-1].node[2*gi] + g_lvl[gl-1].node[2*gi+1];
                end
            end
        end
    endgenerate

    assign tree_sum = g_lvl[TREE_LEVELS].node[0];

    // Accumulate in ACC_WIDTH+1 bits; the extra bit exposes carry (unsigned)
    // or the true sign (signed) for overflow detection and clamp direction.
    always_comb begin
        acc_wide = {signed_reg & acc_reg[ACC_WIDTH-1], acc_reg} +
                   {signed_reg & tree_sum[ACC_WIDTH-1], tree_sum};
        if (signed_reg) acc_ovf = acc_wide[ACC_WIDTH] ^ acc_wide[ACC_WIDTH-1];
        else            acc_ovf = acc_wide[ACC_WIDTH];
        if (!signed_reg)            sat_val = SAT_UMAX;
        else if (acc_wide[ACC_WIDTH]) sat_val = SAT_SMIN;
        else                        sat_val = SAT_SMAX;
        acc_next = (acc_ovf && sat_reg) ? sat_val : acc_wide[ACC_WIDTH-1:0];
    end

    always_comb begin
        skip_beat = '0;
        for (int i = 0; i < LANES; i++) begin
            skip_beat = skip_beat + SKIP_W'(lane_skip[i]);
        end
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start)
                          state_next = (vec_len == '0) ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (accept && (beat_cnt_next == len_reg))
                          state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt_reg)
                          state_next = ST_DONE;
            ST_DONE:  if (result_valid_reg && result_ready)
                          state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg          <= '0;
            beat_cnt_reg     <= '0;
            signed_reg       <= 1'b0;
            sat_reg          <= 1'b0;
            drain_cnt_reg    <= 1'b0;
            s1_valid_reg     <= 1'b0;
            acc_reg          <= '0;
            clamped_reg      <= 1'b0;
            overflow_reg     <= 1'b0;
            skip_reg         <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg  <= accept;
            drain_cnt_reg <= (state_reg == ST_DRAIN) ? ~drain_cnt_reg : 1'b0;

            if (start_ok) begin
                len_reg      <= vec_len;
                signed_reg   <= signed_mode;
                sat_reg      <= sat_en;
                beat_cnt_reg <= '0;
                acc_reg      <= '0;
                clamped_reg  <= 1'b0;
                overflow_reg <= 1'b0;
                skip_reg     <= '0;
            end

            if (accept) begin
                beat_cnt_reg <= beat_cnt_next;
                skip_reg     <= skip_reg + skip_beat;
            end

            // A clamped accumulator ignores the remaining beats of the run.
            if (s1_valid_reg && !clamped_reg) begin
                acc_reg <= acc_next;
                if (acc_ovf) begin
                    overflow_reg <= 1'b1;
                    if (sat_reg) clamped_reg <= 1'b1;
                end
            end

            if (state_reg == ST_DONE) begin
                if (result_valid_reg && result_ready) begin
                    result_valid_reg <= 1'b0;
                end else begin
                    result_valid_reg <= 1'b1;
                    result_reg       <= acc_reg;
                end
            end
        end
    end

    assign ready_in     = (state_reg == ST_ACCUM);
    assign busy         = (state_reg != ST_IDLE);
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign overflow     = overflow_reg;
    assign skip_count   = skip_reg;

endmodule

// File: tb/tb_dot_product_engine.sv
// -----------------------------------------------------------------------------
// tb_dot_product_engine
// Table of directed dot-product runs with hand-computed results, plus
// sequences for saturation/wrap on a 34-bit accumulator, mid-run reset and
// the DONE hold behaviour. Both engines share the same input stimulus.
// -----------------------------------------------------------------------------
module tb_dot_product_engine;

    typedef struct packed {
        logic [7:0]        len;
        logic              sgn;
        logic              sat;
        logic [3:0]        gap;
        logic [3:0][63:0]  a;
        logic [3:0][63:0]  b;
        logic [39:0]       exp_res;
        logic [10:0]       exp_skip;
        logic              exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  vec_len;
    logic        signed_mode, sat_en, valid_in, result_ready;
    logic [63:0] a_vec, b_vec;

    logic        ready_in, result_valid, busy, overflow;
    logic [39:0] result;
    logic [10:0] skip_count;

    logic        ready34, rv34, busy34, ovf34;
    logic [33:0] res34;
    logic [10:0] skip34;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dot_product_engine u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vec_len      (vec_len),
        .signed_mode  (signed_mode),
        .sat_en       (sat_en),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .a_vec        (a_vec),
        .b_vec        (b_vec),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overflow     (overflow),
        .skip_count   (skip_count)
    );

    dot_product_engine #(.ACC_WIDTH(34)) u_dut34 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vec_len      (vec_len),
        .signed_mode  (signed_mode),
        .sat_en       (sat_en),
        .valid_in     (valid_in),
        .ready_in     (ready34),
        .a_vec        (a_vec),
        .b_vec        (b_vec),
        .result       (res34),
        .result_valid (rv34),
        .result_ready (result_ready),
        .busy         (busy34),
        .overflow     (ovf34),
        .skip_count   (skip34)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] p4(input int l0, input int l1, input int l2, input int l3);
        logic [63:0] r;
        r = {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
        return r;
    endfunction

    function automatic vec_t mk(input int len, input bit sgn, input bit sat, input int gap,
                                input logic [63:0] a0, input logic [63:0] b0,
                                input logic [63:0] a1, input logic [63:0] b1,
                                input logic [39:0] er, input int es, input bit eo);
        vec_t v;
        v          = '0;
        v.len      = 8'(len);
        v.sgn      = sgn;
        v.sat      = sat;
        v.gap      = 4'(gap);
        v.a[0]     = a0;
        v.b[0]     = b0;
        v.a[1]     = a1;
        v.b[1]     = b1;
        v.exp_res  = er;
        v.exp_skip = 11'(es);
        v.exp_ovf  = eo;
        return v;
    endfunction

    // Runs one dot product on the shared inputs and leaves both engines in DONE.
    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        start       = 1'b1;
        vec_len     = v.len;
        signed_mode = v.sgn;
        sat_en      = v.sat;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(v.len); i++) begin
            chk({nm, "/ready_in"}, 64'(ready_in), 64'd1);
            valid_in = 1'b1;
            a_vec    = v.a[i];
            b_vec    = v.b[i];
            @(negedge clk);
            // Junk on the bus while idle must not reach the accumulator.
            valid_in = 1'b0;
            a_vec    = {$urandom, $urandom};
            b_vec    = {$urandom, $urandom};
            if (i < int'(v.len) - 1) repeat (int'(v.gap)) @(negedge clk);
        end
        // Last acceptance (or start for an empty run) was edge k.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({nm, "/valid_k+2"}, 64'(result_valid), 64'd0);
        @(negedge clk);
        chk({nm, "/valid_k+3"}, 64'(result_valid), 64'd1);
        chk({nm, "/result"},    64'(result),       64'(v.exp_res));
        chk({nm, "/skip"},      64'(skip_count),   64'(v.exp_skip));
        chk({nm, "/overflow"},  64'(overflow),     64'(v.exp_ovf));
        $display("%s: len=%0d sgn=%0d sat=%0d result=0x%0h skip=%0d ovf=%0d",
                 nm, v.len, v.sgn, v.sat, result, skip_count, overflow);
    endtask

    task automatic release_done(input string nm);
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({nm, "/idle_busy"},  64'(busy),         64'd0);
        chk({nm, "/idle_valid"}, 64'(result_valid), 64'd0);
    endtask

    vec_t tbl [10];
    vec_t v;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; vec_len = '0; signed_mode = 1'b0; sat_en = 1'b0;
        valid_in = 1'b0; a_vec = '0; b_vec = '0; result_ready = 1'b0;

        tbl[0] = mk(1, 0, 0, 0, p4(3, 4, 5, 0), p4(2, 6, 1, 7), '0, '0, 40'd35, 1, 0);
        tbl[1] = mk(2, 0, 0, 2, p4(10, 20, 0, 0), p4(3, 5, 0, 0),
                    p4(1, 1, 1, 1), p4(1, 1, 1, 1), 40'd134, 2, 0);
        tbl[2] = mk(1, 1, 0, 0, p4(-3, 2, 0, 0), p4(5, -4, 0, 0), '0, '0, 40'hFF_FFFF_FFE9, 2, 0);
        tbl[3] = mk(0, 0, 0, 0, '0, '0, '0, '0, 40'd0, 0, 0);
        tbl[4] = mk(1, 0, 0, 0, '1, '1, '0, '0, 40'h3_FFF8_0004, 0, 0);
        tbl[5] = mk(1, 1, 0, 0, '1, p4(1, 1, 1, 1), '0, '0, 40'hFF_FFFF_FFFC, 0, 0);
        tbl[6] = mk(1, 0, 0, 0, '1, p4(1, 1, 1, 1), '0, '0, 40'h3_FFFC, 0, 0);
        tbl[7] = mk(1, 0, 0, 0, '0, p4(1, 2, 3, 4), '0, '0, 40'd0, 4, 0);
        tbl[8] = mk(1, 1, 0, 0, p4(-32768, -32768, -32768, -32768),
                    p4(-32768, -32768, -32768, -32768), '0, '0, 40'h1_0000_0000, 0, 0);
        // -42 + 6 (lanes 2,3 skipped) then 5+12+21+32 = 34
        tbl[9] = mk(2, 1, 1, 0, p4(7, -2, 0, 100), p4(-6, -3, 9, 0),
                    p4(1, 2, 3, 4), p4(5, 6, 7, 8), 40'd34, 2, 0);

        repeat (2) @(negedge clk);
        chk("reset/ready_in",     64'(ready_in),     64'd0);
        chk("reset/busy",         64'(busy),         64'd0);
        chk("reset/result",       64'(result),       64'd0);
        chk("reset/result_valid", 64'(result_valid), 64'd0);
        chk("reset/overflow",     64'(overflow),     64'd0);
        chk("reset/skip",         64'(skip_count),   64'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 10; t++) begin
            run_vec(tbl[t], $sformatf("vec%0d", t));
            release_done($sformatf("vec%0d", t));
        end

        // Unsigned, 4 beats of 0xFFFF: 4 x 0x3FFF80004 = 0xFFFE00010.
        v = mk(4, 0, 1, 0, '1, '1, '1, '1, 40'hF_FFE0_0010, 0, 0);
        v.a[2] = '1; v.b[2] = '1; v.a[3] = '1; v.b[3] = '1;
        run_vec(v, "usat");
        chk("usat/res34",   64'(res34), 64'h3_FFFF_FFFF);
        chk("usat/ovf34",   64'(ovf34), 64'd1);
        chk("usat/valid34", 64'(rv34),  64'd1);
        release_done("usat");
        v.sat = 1'b0;
        run_vec(v, "uwrap");
        chk("uwrap/res34", 64'(res34), 64'h3_FFE0_0010);
        chk("uwrap/ovf34", 64'(ovf34), 64'd1);
        release_done("uwrap");

        // Signed: +2^32, +2^32 clamps to max; a negative third beat must not
        // pull the clamped value back. 40-bit sum: 2^33 - 0xFFFE0000.
        v = mk(3, 1, 1, 0, p4(-32768, -32768, -32768, -32768), p4(-32768, -32768, -32768, -32768),
               p4(-32768, -32768, -32768, -32768), p4(-32768, -32768, -32768, -32768),
               40'h1_0002_0000, 0, 0);
        v.a[2] = p4(-32768, -32768, -32768, -32768);
        v.b[2] = p4(32767, 32767, 32767, 32767);
        run_vec(v, "ssat_pos");
        chk("ssat_pos/res34", 64'(res34), 64'h1_FFFF_FFFF);
        chk("ssat_pos/ovf34", 64'(ovf34), 64'd1);
        release_done("ssat_pos");

        // Signed: three beats of -0xFFFE0000 each fall below -2^33.
        v.a[0] = v.a[2]; v.b[0] = v.b[2]; v.a[1] = v.a[2]; v.b[1] = v.b[2];
        v.exp_res = 40'hFD_0006_0000;
        run_vec(v, "ssat_neg");
        chk("ssat_neg/res34", 64'(res34), 64'h2_0000_0000);
        chk("ssat_neg/ovf34", 64'(ovf34), 64'd1);
        release_done("ssat_neg");

        // Reset during the second beat of a four-beat run.
        @(negedge clk);
        start = 1'b1; vec_len = 8'd4; signed_mode = 1'b0; sat_en = 1'b0;
        @(negedge clk);
        start = 1'b0; valid_in = 1'b1; a_vec = tbl[0].a[0]; b_vec = tbl[0].b[0];
        @(negedge clk);
        chk("rstmid/skip_before", 64'(skip_count), 64'd1);
        a_vec = p4(9, 9, 9, 9); b_vec = p4(9, 9, 9, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid/ready_in",     64'(ready_in),     64'd0);
        chk("rstmid/busy",         64'(busy),         64'd0);
        chk("rstmid/result",       64'(result),       64'd0);
        chk("rstmid/result_valid", 64'(result_valid), 64'd0);
        chk("rstmid/overflow",     64'(overflow),     64'd0);
        chk("rstmid/skip",         64'(skip_count),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid/no_restart_busy",  64'(busy),     64'd0);
            chk("rstmid/no_restart_ready", 64'(ready_in), 64'd0);
        end
        valid_in = 1'b0;
        run_vec(tbl[0], "after_rst");
        release_done("after_rst");

        // DONE holds for five cycles with result_ready low; start is ignored.
        run_vec(tbl[1], "hold");
        start = 1'b1; vec_len = 8'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold/result", 64'(result),       64'd134);
            chk("hold/valid",  64'(result_valid), 64'd1);
            chk("hold/busy",   64'(busy),         64'd1);
            chk("hold/skip",   64'(skip_count),   64'd2);
        end
        start = 1'b0;
        release_done("hold");
        @(negedge clk);
        chk("hold/stay_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
